// File: rtl/cdc_req_ack_tx.sv
// Source-side sequencer for a 4-phase req/ack handshake into another clock domain.
// ACK_SYNC is expected to arrive already synchronized into CLK.
module cdc_req_ack_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int TO_WIDTH   = 8,
  parameter int TIMEOUT    = 200
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  ACK_SYNC,
  input  logic                  CLR_ERR,
  output logic                  REQ,
  output logic [DATA_WIDTH-1:0] HOLD_DATA,
  output logic                  DONE,
  output logic                  TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2,
    ERR       = 2'd3
  } state_e;

  localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  expired;

  // A lingering ack from the previous transfer blocks acceptance so the
  // destination never sees a new request before it has released ack.
  assign IN_READY = (state_q == IDLE) && !ACK_SYNC;
  assign accept   = IN_VALID && IN_READY;
  assign expired  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = IN_DATA;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Exit condition wins over an expiring counter in the same cycle.
        if (ACK_SYNC) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_NACK;
        end else if (expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      WAIT_NACK: begin
        if (!ACK_SYNC) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expired) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      ERR: begin
        req_d = 1'b0;
        if (CLR_ERR && !ACK_SYNC) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign REQ         = req_q;
  assign HOLD_DATA   = hold_q;
  assign DONE        = done_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// Directed bench for cdc_req_ack_tx; completed words are checked against a
// queue of expected HOLD_DATA values whenever DONE pulses.
module tb_cdc_req_ack_tx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic          ACK_SYNC;
  logic          CLR_ERR;
  logic          REQ;
  logic [DW-1:0] HOLD_DATA;
  logic          DONE;
  logic          TIMEOUT_ERR;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  cdc_req_ack_tx #(.DATA_WIDTH(DW), .TO_WIDTH(8), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .ACK_SYNC(ACK_SYNC), .CLR_ERR(CLR_ERR),
    .REQ(REQ), .HOLD_DATA(HOLD_DATA), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding word.
  always @(negedge CLK) begin
    if (!RST && DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(DONE), 32'h0);
      end else begin
        chk("done_data", 32'(HOLD_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_DATA = '0; IN_VALID = 1'b0; ACK_SYNC = 1'b0; CLR_ERR = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_req", 32'(REQ), 0);
    chk("rst_hold", 32'(HOLD_DATA), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_terr", 32'(TIMEOUT_ERR), 0);
    chk("rst_ready", 32'(IN_READY), 1);

    // Basic transfer, ack rises 2 cycles after REQ
    IN_DATA = 8'hA5; IN_VALID = 1'b1; exp_q.push_back(8'hA5);
    tick();
    IN_VALID = 1'b0; IN_DATA = 8'h00;
    chk("a5_req_set", 32'(REQ), 1);
    chk("a5_hold", 32'(HOLD_DATA), 32'hA5);
    chk("a5_ready_busy", 32'(IN_READY), 0);
    tick(); tick();
    ACK_SYNC = 1'b1;
    tick();
    chk("a5_req_fall", 32'(REQ), 0);
    chk("a5_no_done_yet", 32'(DONE), 0);
    tick();
    chk("a5_hold_stable", 32'(HOLD_DATA), 32'hA5);
    chk("a5_ready_ack_hi", 32'(IN_READY), 0);
    ACK_SYNC = 1'b0;
    tick();
    chk("a5_done", 32'(DONE), 1);
    tick();
    chk("a5_done_single", 32'(DONE), 0);

    // Timeout in WAIT_ACK
    IN_DATA = 8'h3C; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    chk("toa_req_before", 32'(REQ), 1);
    chk("toa_terr_before", 32'(TIMEOUT_ERR), 0);
    tick();
    chk("toa_req_err", 32'(REQ), 0);
    chk("toa_terr", 32'(TIMEOUT_ERR), 1);
    chk("toa_hold", 32'(HOLD_DATA), 32'h3C);
    IN_VALID = 1'b1; IN_DATA = 8'hEE;
    #1;
    chk("toa_ready_err", 32'(IN_READY), 0);
    tick();
    chk("toa_valid_ignored", 32'(HOLD_DATA), 32'h3C);
    chk("toa_terr_hold", 32'(TIMEOUT_ERR), 1);
    IN_VALID = 1'b0; CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("toa_clr_terr", 32'(TIMEOUT_ERR), 0);
    chk("toa_clr_ready", 32'(IN_READY), 1);

    // Ack stuck high in WAIT_NACK
    IN_DATA = 8'h5A; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; ACK_SYNC = 1'b1;
    tick();
    chk("tan_req_fall", 32'(REQ), 0);
    tick(); tick(); tick();
    chk("tan_terr_before", 32'(TIMEOUT_ERR), 0);
    tick();
    chk("tan_terr", 32'(TIMEOUT_ERR), 1);
    chk("tan_hold", 32'(HOLD_DATA), 32'h5A);
    CLR_ERR = 1'b1;
    tick();
    chk("tan_clr_ignored", 32'(TIMEOUT_ERR), 1);
    ACK_SYNC = 1'b0;
    #1;
    chk("tan_ready_err", 32'(IN_READY), 0);
    tick();
    CLR_ERR = 1'b0;
    chk("tan_clr_terr", 32'(TIMEOUT_ERR), 0);
    chk("tan_clr_ready", 32'(IN_READY), 1);

    // Reset mid-transfer
    IN_DATA = 8'h77; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("rstm_req_set", 32'(REQ), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstm_req", 32'(REQ), 0);
    chk("rstm_hold", 32'(HOLD_DATA), 0);
    chk("rstm_done", 32'(DONE), 0);
    chk("rstm_ready", 32'(IN_READY), 1);
    tick(); tick();

    // Back-to-back with IN_VALID held high
    IN_DATA = 8'h01; IN_VALID = 1'b1; exp_q.push_back(8'h01);
    tick();
    IN_DATA = 8'h02; exp_q.push_back(8'h02);
    chk("b2b_req1", 32'(REQ), 1);
    chk("b2b_ready1", 32'(IN_READY), 0);
    ACK_SYNC = 1'b1;
    tick();
    chk("b2b_ready2", 32'(IN_READY), 0);
    chk("b2b_hold1", 32'(HOLD_DATA), 32'h01);
    ACK_SYNC = 1'b0;
    #1;
    chk("b2b_ready3", 32'(IN_READY), 0);
    tick();
    chk("b2b_done1", 32'(DONE), 1);
    chk("b2b_hold_at_done", 32'(HOLD_DATA), 32'h01);
    chk("b2b_ready_after", 32'(IN_READY), 1);
    tick();
    IN_VALID = 1'b0;
    chk("b2b_req2", 32'(REQ), 1);
    chk("b2b_hold2", 32'(HOLD_DATA), 32'h02);
    chk("b2b_done_low", 32'(DONE), 0);
    ACK_SYNC = 1'b1;
    tick();
    ACK_SYNC = 1'b0;
    tick();
    chk("b2b_done2", 32'(DONE), 1);

    // Ack arrives exactly as the counter reaches TIMEOUT-1
    IN_DATA = 8'h99; IN_VALID = 1'b1; exp_q.push_back(8'h99);
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    ACK_SYNC = 1'b1;
    tick();
    chk("prio_terr", 32'(TIMEOUT_ERR), 0);
    chk("prio_req", 32'(REQ), 0);
    ACK_SYNC = 1'b0;
    tick();
    chk("prio_done", 32'(DONE), 1);
    tick(); tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
